// File: rtl/spi_stream_tx_if.sv
// spi_stream_tx_if: host SPI pins, sample-source word port and capture status
// bundled for spi_stream_tx. The slave modport is the engine's view; the master
// modport is the host/source side.
interface spi_stream_tx_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 20
);
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              cap_start;
  logic              rd_word_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_word;
  logic              rd_word_vld;
  logic              capture_busy;
  logic              capture_done;
  logic [ADDR_W-1:0] sample_count;

  modport slave (
    input  cs_n, mosi, rd_word, rd_word_vld, capture_busy, capture_done, sample_count,
    output miso, miso_oe, cap_start, rd_word_req, rd_addr
  );

  modport master (
    output cs_n, mosi, rd_word, rd_word_vld, capture_busy, capture_done, sample_count,
    input  miso, miso_oe, cap_start, rd_word_req, rd_addr
  );
endinterface

// File: rtl/spi_stream_tx.sv
// spi_stream_tx: SPI-slave transmit engine running on the host's sclk.
// Decodes an 8-bit command (START / READ_CONT / READ_STATUS / READ_DATA) and
// answers on miso with a 24-bit status word or a stream of sample words pulled
// from the capture store through a request/valid word port.
// Optional feature macro: SPI_TX_CRC8_EN appends CRC-8 (poly 0x07, init 0x00)
// after every streamed word, stretching the word period from 16 to 24 bits.
module spi_stream_tx #(
  parameter int WORD_W    = 16,
  parameter int ADDR_W    = 20,
  parameter int MAX_WORDS = 96000
) (
  input logic            sclk,
  input logic            reset_n,
  spi_stream_tx_if.slave bus
);

`ifdef SPI_TX_CRC8_EN
  localparam int P = WORD_W + 8;
`else
  localparam int P = WORD_W;
`endif
  // shift register must hold either a word plus CRC slot or the status word
  localparam int SR_W = (WORD_W + 8 > ADDR_W + 4) ? WORD_W + 8 : ADDR_W + 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_STATUS = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_SINK   = 3'd4;

  localparam logic [7:0] C_START  = 8'h00;
  localparam logic [7:0] C_RDCONT = 8'h01;
  localparam logic [7:0] C_RDSTAT = 8'h02;
  localparam logic [7:0] C_RDDATA = 8'h03;

  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(MAX_WORDS);

  logic [2:0]        state;
  logic [2:0]        bcnt;
  logic [6:0]        cmd;
  logic [4:0]        ph, ph_nxt;
  logic [SR_W-1:0]   sr;
  logic [ADDR_W-1:0] saddr;
  logic              underrun;
  logic              oe_r, cap_r, req_r;
  logic [ADDR_W-1:0] addr_r;

  logic [7:0]        cmd_full;
  logic              at_end;
  logic [WORD_W-1:0] ld_word;
  logic [SR_W-1:0]   ld_vec, st_vec;
  logic [ADDR_W-1:0] first_addr;

`ifdef SPI_TX_CRC8_EN
  function automatic logic [7:0] crc8(input logic [WORD_W-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = WORD_W - 1; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
`endif

  // load/status images and phase bookkeeping for the current edge
  always_comb begin
    cmd_full   = {cmd, bus.mosi};
    at_end     = (saddr == END_ADDR);
    ph_nxt     = (ph == 5'(P - 1)) ? 5'd0 : ph + 5'd1;
    first_addr = (cmd_full == C_RDDATA) ? '0 : saddr;
    // past the end of the capture the host just sees zeros, no underrun
    ld_word    = at_end ? '0 : (bus.rd_word_vld ? bus.rd_word : '1);
    ld_vec     = '0;
    ld_vec[SR_W-1 -: WORD_W] = ld_word;
`ifdef SPI_TX_CRC8_EN
    ld_vec[SR_W-1-WORD_W -: 8] = crc8(ld_word);
`endif
    st_vec     = '0;
    st_vec[SR_W-1 -: ADDR_W+4] = {bus.capture_busy, bus.capture_done, underrun, 1'b0,
                                  bus.sample_count};
  end

  // frame FSM, shift register, word requests and saved address
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      bcnt     <= '0;
      cmd      <= '0;
      ph       <= '0;
      sr       <= '0;
      saddr    <= '0;
      underrun <= 1'b0;
      oe_r     <= 1'b0;
      cap_r    <= 1'b0;
      req_r    <= 1'b0;
      addr_r   <= '0;
    end else if (bus.cs_n) begin
      // frame over: anything partly shifted is dropped
      state <= S_IDLE;
      sr    <= '0;
      oe_r  <= 1'b0;
      cap_r <= 1'b0;
      req_r <= 1'b0;
    end else begin
      cap_r <= 1'b0;
      req_r <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd   <= {cmd[5:0], bus.mosi};
          bcnt  <= 3'd1;
          oe_r  <= 1'b1;
          sr    <= '0;
          state <= S_CMD;
        end
        S_CMD: begin
          cmd  <= {cmd[5:0], bus.mosi};
          bcnt <= bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            case (cmd_full)
              C_START: begin
                cap_r <= 1'b1;
                saddr <= '0;
                state <= S_SINK;
              end
              C_RDCONT, C_RDDATA: begin
                ph    <= '0;
                state <= S_DATA;
                if (cmd_full == C_RDDATA) saddr <= '0;
                if (first_addr != END_ADDR) begin
                  req_r  <= 1'b1;
                  addr_r <= first_addr;
                end
              end
              C_RDSTAT: begin
                sr       <= st_vec;
                underrun <= 1'b0;
                state    <= S_STATUS;
              end
              default: state <= S_SINK;
            endcase
          end
        end
        S_STATUS: sr <= sr << 1;
        S_DATA: begin
          ph <= ph_nxt;
          if (ph_nxt == 5'd8) begin
            // load edge: 8 periods after the request went out
            sr <= ld_vec;
            if (!at_end) begin
              saddr <= saddr + 1'b1;
              if (!bus.rd_word_vld) underrun <= 1'b1;
            end
          end else begin
            sr <= sr << 1;
          end
          if (ph_nxt == 5'd0 && !at_end) begin
            req_r  <= 1'b1;
            addr_r <= saddr;
          end
        end
        default: sr <= '0;
      endcase
    end
  end

  assign bus.miso        = sr[SR_W-1];
  assign bus.miso_oe     = oe_r;
  assign bus.cap_start   = cap_r;
  assign bus.rd_word_req = req_r;
  assign bus.rd_addr     = addr_r;

endmodule
